ifm_rd_addr_gen: RTL and testbench
==================================

Name: ifm_rd_addr_gen

Overview:
- Generates compressed-IFM read addresses from a sparsemap window and the priority-encoder match index.
- Sits between the IFM sparsemap fetch/priority encoder and the IFM data chunk buffer.
- Parametrised successor of the compile-time-selected input selector: padding and stacking modes are selected at run time, lane count is a parameter, the output is a registered valid/stall pipeline, and overflow detection is added.

Parameters:
- PS_SIZE, 8, sparsemap window width (lanes per prefix sum).
- CHUNK_SIZE, 64, compressed data entries per chunk; AW = $clog2(CHUNK_SIZE)+1.
- CYC_NUM, 4, sparsemap windows per sub-chunk; CW = $clog2(CYC_NUM) (min 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mode_i  in  1  0 = channel padding, 1 = channel stacking; sampled on sub_chunk_start_i.
- sparsemap_i  in  PS_SIZE  current sparsemap window.
- match_vld_i  in  1  priority-encoder match valid.
- match_addr_i  in  $clog2(PS_SIZE)  matched lane index.
- pri_enc_end_i  in  1  last match of the current window.
- sub_chunk_start_i  in  1  first cycle of a new sub-chunk.
- sm_addr_i  in  CW  index of the current window within the sub-chunk.
- sm_first_i  in  CW  window index at which the next sub-chunk base is captured (stacking).
- sm_next_i  in  CW  lane offset of the next sub-chunk inside that window; 0 means the next base is 0.
- stall_i  in  1  downstream stall; freezes outputs and all state.
- rd_vld_o  out  1  read address valid.
- rd_addr_o  out  AW  compressed data read address.
- ovf_o  out  1  sticky overflow flag.

Behaviour:
- Arithmetic:
  - pre[k] = popcount(sparsemap_i[k-1:0]), exclusive; pre[0] = 0.
  - tot = popcount(sparsemap_i).
  - All sums are AW-bit and wrap modulo 2^AW.
- Effective base: base_w = sub_chunk_start_i ? start_val : base_r.
  - start_val = (mode_i==1) ? next_base_r : 0.
- Address path: addr_c = base_w + pre[match_addr_i].
- Output stage, one cycle latency, when !stall_i:
  - rd_vld_o <= match_vld_i.
  - rd_addr_o <= addr_c if match_vld_i, else it holds.
- Stall:
  - When stall_i=1, every register holds and all inputs are ignored.
  - Upstream must hold its inputs while stalled.
- base_r update when !stall_i:
  - If pri_enc_end_i: base_r <= base_w + tot. This covers a start and end in the same cycle (single-window sub-chunk).
  - Else if sub_chunk_start_i: base_r <= start_val.
  - Else: base_r holds.
- mode_r is loaded with mode_i on sub_chunk_start_i. The stacking capture uses mode_r, or mode_i in the start cycle.
- next_base_r (stacking only), when !stall_i:
  - If sm_next_i==0: next_base_r <= 0.
  - Else if sm_addr_i==sm_first_i: next_base_r <= base_w + pre[sm_next_i].
  - Otherwise it holds. In padding mode it holds.
- ovf_o:
  - Set when a valid output would have addr_c >= CHUNK_SIZE, or when a base_r update produces a value > CHUNK_SIZE.
  - Cleared only by reset. The address is still emitted, wrapped.
- Reset (asynchronous, rst_ni=0) values:
  - rd_vld_o=0, rd_addr_o=0, ovf_o=0.
  - base_r=0, next_base_r=0, mode_r=0.
- Reset mid-sub-chunk discards all state. The first address after reset needs sub_chunk_start_i.
- Clock gating is not used inside this block; use register enables only.

Decomposition:
- Shared package ifm_addr_pkg holds:
  - the mode enum (MODE_PAD, MODE_STACK);
  - width functions for AW and CW;
  - a popcount function.
- One sub-module, ifm_prefix_popcnt (parametrised PS_SIZE), produces the pre[] array and tot combinationally.

Test Plan:
- Padding mode, sub_chunk_start_i with sparsemap 8'b1011_0010 and match lanes 1,4,5,7 (last with pri_enc_end_i) -> rd_addr_o = 0,1,2,3 one cycle later. The next window 8'hFF with match lane 0 -> addr 4.
- Stacking mode, CYC_NUM=4, sm_first_i=2, sm_next_i=3, window 2 = 8'b0000_0101 with base_r=9 -> next_base_r=11. The following sub_chunk_start_i with match lane 0 -> rd_addr_o=11.
- Simultaneous sub_chunk_start_i and pri_enc_end_i in padding mode, sparsemap 8'h0F -> base_r=4. The next match lane 2 of 8'h07 -> addr 6.
- Stall: assert stall_i for 3 cycles mid-stream with changing inputs -> rd_addr_o, rd_vld_o and base_r are unchanged. Resume -> the sequence continues with no loss or duplication.
- Overflow: CHUNK_SIZE=64, base_r driven to 62, match lane 3 of 8'hFF -> ovf_o=1, rd_addr_o=65 (wrapped in 7 bits). ovf_o stays 1 until rst_ni falls.
- Asynchronous reset asserted mid-cycle during stacking -> all outputs and state go to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/ifm_addr_pkg.sv
// Shared types and helpers for the IFM read-address generator.
package ifm_addr_pkg;

  typedef enum logic {
    MODE_PAD   = 1'b0,
    MODE_STACK = 1'b1
  } mode_e;

  // Widest sparsemap window the popcount helper handles.
  localparam int MAX_PS = 64;

  // Address width: one extra bit above the chunk index so an overrun stays visible.
  function automatic int addr_width(input int chunk);
    return $clog2(chunk) + 1;
  endfunction

  // Window-index width, never narrower than one bit.
  function automatic int cyc_width(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_PS-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_PS; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ifm_prefix_popcnt.sv
// Exclusive prefix popcounts and total popcount of one sparsemap window.
module ifm_prefix_popcnt
  import ifm_addr_pkg::*;
#(
  parameter int PS_SIZE = 8,
  parameter int CNT_W   = $clog2(PS_SIZE + 1)
) (
  input  logic [PS_SIZE-1:0]            sparsemap,
  output logic [PS_SIZE-1:0][CNT_W-1:0] pre,
  output logic [CNT_W-1:0]              tot
);

  logic [MAX_PS-1:0] win;

  // pre[k] counts the set lanes strictly below lane k; tot counts the whole window.
  always_comb begin
    win = '0;
    win[PS_SIZE-1:0] = sparsemap;
    for (int k = 0; k < PS_SIZE; k++) begin
      pre[k] = CNT_W'(popcount(win & ((MAX_PS'(1) << k) - MAX_PS'(1))));
    end
    tot = CNT_W'(popcount(win));
  end

endmodule

// File: rtl/ifm_rd_addr_gen.sv
// Compressed-IFM read-address generator: base tracking, stacking hand-over,
// registered valid/stall output stage and sticky overflow flag.
module ifm_rd_addr_gen
  import ifm_addr_pkg::*;
#(
  parameter int PS_SIZE    = 8,
  parameter int CHUNK_SIZE = 64,
  parameter int CYC_NUM    = 4,
  localparam int AW    = addr_width(CHUNK_SIZE),
  localparam int CW    = cyc_width(CYC_NUM),
  localparam int LW    = (PS_SIZE > 1) ? $clog2(PS_SIZE) : 1,
  localparam int CNT_W = $clog2(PS_SIZE + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               mode_i,
  input  logic [PS_SIZE-1:0] sparsemap_i,
  input  logic               match_vld_i,
  input  logic [LW-1:0]      match_addr_i,
  input  logic               pri_enc_end_i,
  input  logic               sub_chunk_start_i,
  input  logic [CW-1:0]      sm_addr_i,
  input  logic [CW-1:0]      sm_first_i,
  input  logic [CW-1:0]      sm_next_i,
  input  logic               stall_i,
  output logic               rd_vld_o,
  output logic [AW-1:0]      rd_addr_o,
  output logic               ovf_o
);

  logic [PS_SIZE-1:0][CNT_W-1:0] pre;
  logic [CNT_W-1:0]              tot;

  mode_e         mode_r;
  logic [AW-1:0] base_r;
  logic [AW-1:0] next_base_r;

  logic [AW-1:0] start_val;
  logic [AW-1:0] base_w;
  logic [AW-1:0] lane_off;
  logic [AW-1:0] next_off;
  logic [AW-1:0] next_cap;
  logic [AW:0]   addr_full;
  logic [AW:0]   base_new;
  logic          base_upd;
  logic          stack_mode;
  logic          ovf_hit;

  ifm_prefix_popcnt #(
    .PS_SIZE (PS_SIZE),
    .CNT_W   (CNT_W)
  ) u_prefix (
    .sparsemap (sparsemap_i),
    .pre       (pre),
    .tot       (tot)
  );

  // Prefix count at the next-sub-chunk lane; an offset past the window means the whole window.
  always_comb begin
    next_off = AW'(tot);
    for (int k = 0; k < PS_SIZE; k++) begin
      if (int'(sm_next_i) == k) begin
        next_off = AW'(pre[k]);
      end
    end
  end

  // Effective base, read address, next base_r value and overflow detection.
  always_comb begin
    start_val  = (mode_e'(mode_i) == MODE_STACK) ? next_base_r : '0;
    base_w     = sub_chunk_start_i ? start_val : base_r;
    stack_mode = sub_chunk_start_i ? mode_i : (mode_r == MODE_STACK);
    lane_off   = AW'(pre[match_addr_i]);
    addr_full  = {1'b0, base_w} + {1'b0, lane_off};
    next_cap   = base_w + next_off;
    base_upd   = 1'b0;
    base_new   = {1'b0, base_r};
    if (pri_enc_end_i) begin
      base_upd = 1'b1;
      base_new = {1'b0, base_w} + (AW+1)'(tot);
    end else if (sub_chunk_start_i) begin
      base_upd = 1'b1;
      base_new = {1'b0, start_val};
    end
    ovf_hit = (match_vld_i && (addr_full >= (AW+1)'(CHUNK_SIZE))) ||
              (base_upd && (base_new > (AW+1)'(CHUNK_SIZE)));
  end

  // Registered output stage; the address holds while no match is valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_o  <= 1'b0;
      rd_addr_o <= '0;
    end else if (!stall_i) begin
      rd_vld_o <= match_vld_i;
      if (match_vld_i) begin
        rd_addr_o <= addr_full[AW-1:0];
      end
    end
  end

  // Base, mode and stacking hand-over registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_r      <= '0;
      next_base_r <= '0;
      mode_r      <= MODE_PAD;
    end else if (!stall_i) begin
      if (base_upd) begin
        base_r <= base_new[AW-1:0];
      end
      if (sub_chunk_start_i) begin
        mode_r <= mode_e'(mode_i);
      end
      if (stack_mode) begin
        if (sm_next_i == '0) begin
          next_base_r <= '0;
        end else if (sm_addr_i == sm_first_i) begin
          next_base_r <= next_cap;
        end
      end
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_o <= 1'b0;
    end else if (!stall_i && ovf_hit) begin
      ovf_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifm_rd_addr_gen.sv
// Self-checking bench for ifm_rd_addr_gen: directed vectors with literal
// expectations plus a cycle model of the addressing rules.
module tb_ifm_rd_addr_gen;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [7:0] sparsemap;
  logic       match_vld;
  logic [2:0] match_addr;
  logic       pri_enc_end;
  logic       sub_chunk_start;
  logic [1:0] sm_addr;
  logic [1:0] sm_first;
  logic [1:0] sm_next;
  logic       stall;
  logic       rd_vld;
  logic [6:0] rd_addr;
  logic       ovf;

  // Literal expectations for the edge following the current stimulus.
  logic pin_en;
  logic pin_vld;
  int   pin_addr;
  logic pin_ovf;

  // Model state.
  int m_vld, m_addr, m_ovf, m_base, m_next, m_mode;

  int checks = 0;
  int fails  = 0;

  ifm_rd_addr_gen #(
    .PS_SIZE    (8),
    .CHUNK_SIZE (64),
    .CYC_NUM    (4)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .mode_i            (mode),
    .sparsemap_i       (sparsemap),
    .match_vld_i       (match_vld),
    .match_addr_i      (match_addr),
    .pri_enc_end_i     (pri_enc_end),
    .sub_chunk_start_i (sub_chunk_start),
    .sm_addr_i         (sm_addr),
    .sm_first_i        (sm_first),
    .sm_next_i         (sm_next),
    .stall_i           (stall),
    .rd_vld_o          (rd_vld),
    .rd_addr_o         (rd_addr),
    .ovf_o             (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pre_of(input logic [7:0] s, input int k);
    int c;
    c = 0;
    for (int i = 0; i < 8 && i < k; i++) c += int'(s[i]);
    return c;
  endfunction

  task automatic checkOutput(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on each edge (or asynchronous reset), then compare 1 time unit later.
  always @(posedge clk or negedge rst_n) begin
    int sv, bw, full, nb, stk;
    if (!rst_n) begin
      m_vld = 0; m_addr = 0; m_ovf = 0; m_base = 0; m_next = 0; m_mode = 0;
    end else if (!stall) begin
      sv = mode ? m_next : 0;
      bw = sub_chunk_start ? sv : m_base;
      if (match_vld) begin
        full = bw + pre_of(sparsemap, int'(match_addr));
        if (full >= 64) m_ovf = 1;
        m_addr = full % 128;
      end
      m_vld = int'(match_vld);
      stk = sub_chunk_start ? int'(mode) : m_mode;
      if (stk != 0) begin
        if (sm_next == 2'd0) m_next = 0;
        else if (sm_addr == sm_first) m_next = (bw + pre_of(sparsemap, int'(sm_next))) % 128;
      end
      if (pri_enc_end) begin
        nb = bw + pre_of(sparsemap, 8);
        if (nb > 64) m_ovf = 1;
        m_base = nb % 128;
      end else if (sub_chunk_start) begin
        if (sv > 64) m_ovf = 1;
        m_base = sv;
      end
      if (sub_chunk_start) m_mode = int'(mode);
    end
    #1;
    checkOutput("rd_vld", int'(rd_vld), m_vld);
    checkOutput("rd_addr", int'(rd_addr), m_addr);
    checkOutput("ovf", int'(ovf), m_ovf);
    checkOutput("base_r", int'(dut.base_r), m_base);
    if (pin_en) begin
      checkOutput("lit_vld", int'(rd_vld), int'(pin_vld));
      checkOutput("lit_addr", int'(rd_addr), pin_addr);
      checkOutput("lit_ovf", int'(ovf), int'(pin_ovf));
      checkOutput("model_addr", m_addr, pin_addr);
    end
  end

  task automatic applyStimulus(input logic st, input logic md, input logic [7:0] sm,
                               input logic vl, input int ln, input logic pe,
                               input int sa, input int sf, input int sn, input logic stl,
                               input logic pv, input int pa, input logic po);
    @(negedge clk);
    sub_chunk_start = st;
    mode            = md;
    sparsemap       = sm;
    match_vld       = vl;
    match_addr      = 3'(ln);
    pri_enc_end     = pe;
    sm_addr         = 2'(sa);
    sm_first        = 2'(sf);
    sm_next         = 2'(sn);
    stall           = stl;
    pin_en          = 1'b1;
    pin_vld         = pv;
    pin_addr        = pa;
    pin_ovf         = po;
  endtask

  task automatic idleInputs();
    sub_chunk_start = 0; mode = 0; sparsemap = 0; match_vld = 0; match_addr = 0;
    pri_enc_end = 0; sm_addr = 0; sm_first = 0; sm_next = 0; stall = 0;
  endtask

  task automatic asyncReset();
    @(posedge clk);
    #3;
    idleInputs();
    pin_vld = 0; pin_addr = 0; pin_ovf = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();
    pin_en = 1'b1; pin_vld = 0; pin_addr = 0; pin_ovf = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] padding sub-chunk");
    applyStimulus(1, 0, 8'b1011_0010, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 8'b1011_0010, 1, 4, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 8'b1011_0010, 1, 5, 0, 0, 0, 0, 0, 1, 2, 0);
    applyStimulus(0, 0, 8'b1011_0010, 1, 7, 1, 0, 0, 0, 0, 1, 3, 0);
    applyStimulus(0, 0, 8'hFF,        1, 0, 1, 0, 0, 0, 0, 1, 4, 0);

    $display("[TB] start and end in one cycle");
    applyStimulus(1, 0, 8'h0F, 0, 0, 1, 0, 0, 0, 0, 0, 4, 0);
    applyStimulus(0, 0, 8'h07, 1, 2, 1, 0, 0, 0, 0, 1, 6, 0);

    $display("[TB] stall");
    applyStimulus(0, 0, 8'hFF, 1, 1, 0, 0, 0, 0, 0, 1, 8, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(logic'(i[0]), 1, 8'(8'h11 * i), 1, 5, 1, i, 1, 3, 1, 1, 8, 0);
    end
    applyStimulus(0, 0, 8'hFF, 1, 2, 1, 0, 0, 0, 0, 1, 9, 0);

    $display("[TB] stacking sub-chunks");
    applyStimulus(1, 1, 8'hFF,        1, 0, 1, 0, 2, 3, 0, 1, 0,  0);
    applyStimulus(0, 0, 8'h01,        1, 0, 1, 1, 2, 3, 0, 1, 8,  0);
    applyStimulus(0, 0, 8'b0000_0101, 1, 2, 1, 2, 2, 3, 0, 1, 10, 0);
    applyStimulus(0, 0, 8'h00,        0, 0, 1, 3, 2, 3, 0, 0, 10, 0);
    applyStimulus(1, 1, 8'h01,        1, 0, 0, 0, 2, 3, 0, 1, 11, 0);
    applyStimulus(0, 0, 8'hFF,        1, 3, 0, 1, 2, 3, 0, 1, 14, 0);

    $display("[TB] asynchronous reset during stacking");
    asyncReset();

    $display("[TB] overflow");
    applyStimulus(1, 0, 8'hFF, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) applyStimulus(0, 0, 8'hFF, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h3F, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'hFF, 1, 3, 0, 0, 0, 0, 0, 1, 65, 1);
    repeat (2) applyStimulus(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 65, 1);
    asyncReset();
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
